// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// rtl/ipml_sync_prefetch_fifo_v2_0.sv - single-clock FWFT FIFO, SDP RAM plus prefetch buffer
// Optional sticky error flags built when IPML_PREFETCH_FIFO_ERR_FLAG_EN is defined.
module ipml_sync_prefetch_fifo_v2_0 #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WIDTH    = 10,
  parameter int PREFETCH_DEPTH = 2,
  parameter int AF_LEVEL       = (1 << DEPTH_WIDTH) - 4,
  parameter int AE_LEVEL       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_wr_vld,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_en,
  output logic                  o_rd_vld,
  output logic [DEPTH_WIDTH:0]  o_level,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow_err,
  output logic                  o_underflow_err
);

  localparam int LW        = DEPTH_WIDTH + 1;
  localparam int RAM_WORDS = 1 << DEPTH_WIDTH;
  localparam int BPW       = $clog2(PREFETCH_DEPTH);
  localparam int BCW       = $clog2(PREFETCH_DEPTH + 1);
  localparam int PW        = BCW + 1;
  localparam logic [LW-1:0]  RAM_FULL = LW'(RAM_WORDS);
  localparam logic [BPW-1:0] BUF_LAST = BPW'(PREFETCH_DEPTH - 1);
  localparam logic [31:0]    AF_U     = AF_LEVEL;
  localparam logic [31:0]    AE_U     = AE_LEVEL;

  logic [DATA_WIDTH-1:0]  r_mem [RAM_WORDS];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [LW-1:0]          r_ram_cnt;
  logic                   r_wr_vld;
  logic                   r_inflight;
  logic [DATA_WIDTH-1:0]  r_rd_q;
  logic [DATA_WIDTH-1:0]  r_buf [PREFETCH_DEPTH];
  logic [BPW-1:0]         r_head;
  logic [BPW-1:0]         r_tail;
  logic [BCW-1:0]         r_buf_cnt;
  logic [LW-1:0]          r_level;
  logic                   r_almost_full;
  logic                   r_almost_empty;

  logic                   w_rd_vld;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue;
  logic [PW-1:0]          w_pending;
  logic [LW-1:0]          w_ram_cnt_nxt;
  logic [BCW-1:0]         w_buf_cnt_nxt;
  logic [LW-1:0]          w_level_nxt;

  function automatic logic [BPW-1:0] buf_inc(input logic [BPW-1:0] p);
    return (p == BUF_LAST) ? '0 : p + BPW'(1);
  endfunction

  assign w_rd_vld = (r_buf_cnt != '0);
  assign w_push   = i_wr_en & r_wr_vld;
  assign w_pop    = i_rd_en & w_rd_vld;

  // Counting in-flight data keeps the buffer from ever being over-committed.
  assign w_pending = PW'(r_buf_cnt) + PW'(r_inflight) - PW'(w_pop);
  assign w_issue   = (r_ram_cnt != '0) && (w_pending < PW'(PREFETCH_DEPTH));

  assign w_ram_cnt_nxt = r_ram_cnt + LW'(w_push) - LW'(w_issue);
  assign w_buf_cnt_nxt = r_buf_cnt + BCW'(r_inflight) - BCW'(w_pop);
  assign w_level_nxt   = w_ram_cnt_nxt + LW'(w_issue) + LW'(w_buf_cnt_nxt);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_rd_q <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_ram_cnt      <= '0;
      r_wr_vld       <= 1'b0;
      r_inflight     <= 1'b0;
      r_head         <= '0;
      r_tail         <= '0;
      r_buf_cnt      <= '0;
      r_level        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
      end
      if (r_inflight) begin
        r_tail <= buf_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= buf_inc(r_head);
      end
      r_ram_cnt      <= w_ram_cnt_nxt;
      r_wr_vld       <= (w_ram_cnt_nxt != RAM_FULL);
      r_inflight     <= w_issue;
      r_buf_cnt      <= w_buf_cnt_nxt;
      r_level        <= w_level_nxt;
      r_almost_full  <= (32'(w_level_nxt) >= AF_U);
      r_almost_empty <= (32'(w_level_nxt) <= AE_U);
    end
  end

  // Entries are cleared so the head word reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (r_inflight) begin
      r_buf[r_tail] <= r_rd_q;
    end
  end

`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
  logic r_overflow_err;
  logic r_underflow_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_overflow_err  <= r_overflow_err | (i_wr_en & ~r_wr_vld);
      r_underflow_err <= r_underflow_err | (i_rd_en & ~w_rd_vld);
    end
  end

  assign o_overflow_err  = r_overflow_err;
  assign o_underflow_err = r_underflow_err;
`else
  assign o_overflow_err  = 1'b0;
  assign o_underflow_err = 1'b0;
`endif

  assign o_wr_vld       = r_wr_vld;
  assign o_rd_vld       = w_rd_vld;
  assign o_rd_data      = r_buf[r_head];
  assign o_level        = r_level;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// tb/tb_ipml_sync_prefetch_fifo_v2_0.sv - scoreboard bench for ipml_sync_prefetch_fifo_v2_0
module tb_ipml_sync_prefetch_fifo_v2_0;

  localparam int DW  = 16;
  localparam int AWD = 3;
  localparam int AF  = 4;
  localparam int AE  = 2;
`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk;
  logic          i_rst_n;
  logic [DW-1:0] i_wr_data;
  logic          i_wr_en;
  logic          o_wr_vld;
  logic [DW-1:0] o_rd_data;
  logic          i_rd_en;
  logic          o_rd_vld;
  logic [AWD:0]  o_level;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          o_overflow_err;
  logic          o_underflow_err;

  int            n_total;
  int            n_bad;
  int            lvl;
  int            n_pop;
  logic [DW-1:0] sb [$];

  ipml_sync_prefetch_fifo_v2_0 #(
    .DATA_WIDTH     (DW),
    .DEPTH_WIDTH    (AWD),
    .PREFETCH_DEPTH (2),
    .AF_LEVEL       (AF),
    .AE_LEVEL       (AE)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_wr_data       (i_wr_data),
    .i_wr_en         (i_wr_en),
    .o_wr_vld        (o_wr_vld),
    .o_rd_data       (o_rd_data),
    .i_rd_en         (i_rd_en),
    .o_rd_vld        (o_rd_vld),
    .o_level         (o_level),
    .o_almost_full   (o_almost_full),
    .o_almost_empty  (o_almost_empty),
    .o_overflow_err  (o_overflow_err),
    .o_underflow_err (o_underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge: drive, score the handshake, step one rising edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
    logic          push;
    logic          pop;
    logic [DW-1:0] exp;
    i_wr_en   = we;
    i_wr_data = wd;
    i_rd_en   = re;
    push = we & o_wr_vld;
    pop  = re & o_rd_vld;
    if (push) sb.push_back(wd);
    if (pop) begin
      n_pop++;
      if (sb.size() == 0) begin
        check("sb_underrun", 1, 0);
      end else begin
        exp = sb.pop_front();
        check("rd_data", o_rd_data, exp);
      end
    end
    @(posedge clk);
    lvl = lvl + int'(push) - int'(pop);
    @(negedge clk);
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check("level", o_level, lvl);
    check("almost_full", o_almost_full, lvl >= AF);
    check("almost_empty", o_almost_empty, lvl <= AE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n   = 1'b0;
    i_wr_en   = 1'b0;
    i_rd_en   = 1'b0;
    i_wr_data = '0;
    #1;
    check("rst_level", o_level, 0);
    check("rst_rd_vld", o_rd_vld, 0);
    check("rst_wr_vld", o_wr_vld, 0);
    sb.delete();
    lvl = 0;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_vld_rel", o_wr_vld, 1);
    check("rst_ae", o_almost_empty, 1);
    check("rst_af", o_almost_full, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_ovf", o_overflow_err, 0);
    check("rst_unf", o_underflow_err, 0);
  endtask

  task automatic wait_vld(input int max);
    int n;
    n = 0;
    while (!o_rd_vld && n < max) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    check("wait_rd_vld", o_rd_vld, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] stale;
    logic          seen;
    int            guard;
    n_total   = 0;
    n_bad     = 0;
    lvl       = 0;
    n_pop     = 0;
    i_rst_n   = 1'b0;
    i_wr_en   = 1'b0;
    i_rd_en   = 1'b0;
    i_wr_data = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // single-word latency
    cycle(1'b1, 16'h00A5, 1'b0);
    check("lat_e0_rd_vld", o_rd_vld, 0);
    cycle(1'b0, '0, 1'b0);
    check("lat_e1_rd_vld", o_rd_vld, 0);
    cycle(1'b0, '0, 1'b0);
    check("lat_e2_rd_vld", o_rd_vld, 1);
    check("lat_e2_rd_data", o_rd_data, 16'h00A5);
    cycle(1'b0, '0, 1'b1);

    // fill to full
    do_reset();
    guard = 0;
    while (o_wr_vld && guard < 20) begin
      cycle(1'b1, DW'(16'h0100 + guard), 1'b0);
      guard++;
    end
    check("full_words", lvl, 10);
    check("full_wr_vld", o_wr_vld, 0);
    check("full_unf_clear", o_underflow_err, 0);
    cycle(1'b1, 16'h0BAD, 1'b0);
    check("full_drop_wr_vld", o_wr_vld, 0);
    check("full_ovf", o_overflow_err, ERR);

    // drain to empty, then underflow
    guard = 0;
    while (lvl > 0 && guard < 40) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    check("drain_empty", lvl, 0);
    check("drain_wr_vld", o_wr_vld, 1);
    check("drain_rd_vld", o_rd_vld, 0);
    stale = o_rd_data;
    repeat (3) cycle(1'b0, '0, 1'b1);
    check("empty_rd_vld", o_rd_vld, 0);
    check("empty_rd_data_hold", o_rd_data, stale);
    check("empty_unf", o_underflow_err, ERR);
    check("empty_ovf_sticky", o_overflow_err, ERR);

    // streaming order
    do_reset();
    n_pop = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (seen) check("stream_gap", o_rd_vld, 1);
      if (o_rd_vld) seen = 1'b1;
      cycle(1'b1, DW'(i), 1'b1);
    end
    guard = 0;
    while (lvl > 0 && guard < 40) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    check("stream_count", n_pop, 100);

    // reset mid-stream with words held
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, DW'(16'h0500 + i), 1'b0);
    end
    check("mid_held", lvl, 5);
    do_reset();
    cycle(1'b1, 16'h0077, 1'b0);
    wait_vld(10);
    check("mid_first_data", o_rd_data, 16'h0077);
    cycle(1'b0, '0, 1'b1);
    check("mid_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
